// File: rtl/bar_frame_scheduler.sv
// Double-buffered 16-bar scheduler: fills a back buffer over valid/ready,
// commits it to the displayed front buffer at frame_start with peak-hold decay.
module bar_frame_scheduler #(
    parameter int NUM_BARS = 16,
    parameter int BAR_W    = 16,
    parameter int DECAY    = 512,
    localparam int IDX_W   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
    input  logic                      fsm_clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_index,
    input  logic [BAR_W-1:0]          in_value,
    input  logic                      frame_start,
    output logic [NUM_BARS*BAR_W-1:0] bars,
    output logic                      frame_swapped,
    output logic                      stale_frame
);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [BAR_W-1:0] DEC_V = BAR_W'(DECAY);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAR_W-1:0]    r_back      [NUM_BARS];
    logic [BAR_W-1:0]    r_front     [NUM_BARS];
    logic [BAR_W-1:0]    w_dec       [NUM_BARS];
    logic [BAR_W-1:0]    w_front_nxt [NUM_BARS];
    logic [NUM_BARS-1:0] r_mask;
    logic [NUM_BARS-1:0] w_mask_nxt;
    logic [NUM_BARS-1:0] w_sel;
    logic                w_accept;
    logic                w_idx_ok;
    logic                w_full;
    logic                w_commit;
    logic                w_stale;
    logic                r_swapped;
    logic                r_stale;

    // Out-of-range indices are accepted but land nowhere
    always_comb begin
        w_accept   = in_valid && (r_state == FILL);
        w_idx_ok   = 32'(in_index) < NUM_BARS;
        w_sel      = '0;
        if (w_accept && w_idx_ok) begin
            w_sel[in_index] = 1'b1;
        end
        w_mask_nxt = r_mask | w_sel;
        w_full     = &w_mask_nxt;
        w_commit   = frame_start && (r_state == READY);
        w_stale    = frame_start && (r_state == FILL);
    end

    // Saturating decay; a committed bar only wins if it beats the decayed peak
    always_comb begin
        for (int i = 0; i < NUM_BARS; i++) begin
            w_dec[i] = (r_front[i] > DEC_V) ? r_front[i] - DEC_V : '0;
            if (r_state == READY) begin
                w_front_nxt[i] = (r_back[i] >= w_dec[i]) ? r_back[i] : w_dec[i];
            end else begin
                w_front_nxt[i] = w_dec[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        unique case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_full) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (frame_start) begin
                    w_state_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge fsm_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge fsm_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
            r_mask    <= '0;
            r_swapped <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (w_sel[i]) begin
                    r_back[i] <= in_value;
                end
                if (frame_start) begin
                    r_front[i] <= w_front_nxt[i];
                end
            end
            if (w_commit) begin
                r_mask <= '0;
            end else begin
                r_mask <= w_mask_nxt;
            end
            r_swapped <= w_commit;
            r_stale   <= w_stale;
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bars
        assign bars[g*BAR_W +: BAR_W] = r_front[g];
    end

    assign frame_swapped = r_swapped;
    assign stale_frame   = r_stale;

endmodule
